completion_arbiter: RTL
=======================

Name: completion_arbiter

Overview:
- Sits between the execution-latency units (single-cycle ALU path, lw/mul/div multi-cycle stallers) and the Scoreboard's finish port.
- Each unit reports a completed instruction (ROB tag plus destination register) on its own lane. The block buffers each lane in a small FIFO and grants one completion per cycle using round-robin arbitration.
- The grant drives the Scoreboard `instr_to_finish` path. A flush empties all pending completions.

Parameters:
- NUM_UNITS, 4, number of completion lanes (0=ALU, 1=LW, 2=MUL, 3=DIV); must be ≥2.
- ROB_SIZE, 32, Scoreboard entry count; TAG_W = $clog2(ROB_SIZE).
- DEPTH, 4, entries per lane FIFO; power of two, ≥2.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- lane_valid  input  NUM_UNITS  bit i: lane i presents a completion this cycle.
- lane_tag  input  NUM_UNITS*TAG_W  packed ROB tags; lane i occupies [i*TAG_W +: TAG_W].
- lane_rd  input  NUM_UNITS*5  packed destination regs (instr[26:22]); lane i occupies [i*5 +: 5].
- lane_full  output  NUM_UNITS  bit i: lane i FIFO holds DEPTH entries; drives the staller enable low.
- finish_ready  input  1  Scoreboard accepts a finish this cycle.
- finish_valid  output  1  a completion is presented.
- finish_tag  output  TAG_W  ROB tag of the granted completion (to `instr_to_finish`).
- finish_rd  output  5  destination reg of the granted completion.
- finish_lane  output  $clog2(NUM_UNITS)  index of the granted lane.
- flush  input  1  discard all buffered completions.
- overflow  output  1  sticky error: a push was attempted into a full lane.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - All FIFO counts and pointers go to 0; rr_ptr goes to 0; overflow goes to 0.
  - After reset: finish_valid=0, finish_tag=0, finish_rd=0, finish_lane=0, lane_full=0.
  - Reset overrides every other input in the same cycle.
- Push:
  - At a posedge with lane_valid[i]=1 and lane_full[i]=0, {tag, rd} is written to lane i's tail.
  - If lane_full[i]=1, the push is rejected even if lane i is popped in the same cycle. The data is dropped and overflow is set to 1; it stays 1 until reset.
- Latency: an entry pushed at edge N is eligible for grant in cycle N+1, i.e. it is visible on finish_* right after edge N. There is no same-cycle bypass.
- Arbitration (combinational from FIFO heads):
  - Search lanes rr_ptr, rr_ptr+1, … mod NUM_UNITS; grant the first non-empty lane g.
  - finish_valid = any lane non-empty and flush=0.
  - finish_tag, finish_rd and finish_lane come from the head of lane g.
  - When finish_valid=0, finish_tag, finish_rd and finish_lane are driven 0.
- Pop: at a posedge with finish_valid=1 and finish_ready=1, lane g's head is popped and rr_ptr ← (g+1) mod NUM_UNITS.
- No pop: if finish_valid=0 or finish_ready=0, rr_ptr is held. finish_* then holds the same lane and entry, unless a lane with higher rotation priority becomes non-empty.
- Same-lane push and pop in one cycle (lane not full): count is unchanged and FIFO order is preserved.
- Pointer wrap-around: FIFO pointers are log2(DEPTH) bits and wrap naturally. count ranges 0..DEPTH, and lane_full = (count==DEPTH).
- Flush:
  - flush=1 forces finish_valid=0 that cycle.
  - At the posedge, all counts and pointers clear, rr_ptr ← 0, and lane pushes that cycle are discarded (flush wins).
  - overflow is not cleared by flush.
- No tag checking: duplicate tags are passed through unchanged. Ordering within a lane is FIFO; across lanes it follows rotation priority only.

Decomposition:
- Shared Verilog include (ooo_defs.vh) holds:
  - field positions OPC [31:27], RD [26:22], RS1 [21:17], RS2 [16:12];
  - lane IDs LANE_ALU=0, LANE_LW=1, LANE_MUL=2, LANE_DIV=3;
  - default ROB_SIZE/SCORE_SIZE = 32;
  - staller latencies LW=8, MUL=16, DIV=32.
- One sub-module, completion_lane_fifo (params W, DEPTH), instantiated NUM_UNITS times via generate. Ports: clock, reset, clr, push, pop, din, dout, empty, full.

Test Plan:
- Single completion: lane 2 pushes tag=5, rd=9 at edge 1, finish_ready=1 → finish_valid=1, tag=5, rd=9, lane=2 during cycle after edge 1; finish_valid=0 after edge 2.
- Round-robin: all 4 lanes push at edge 1 (tags 10,11,12,13), finish_ready=1 → grants in order 10,11,12,13 on four consecutive cycles; rr_ptr ends at 0.
- Backpressure: lane 1 holds tags 3,4 with finish_ready=0 for 5 cycles → finish_tag stays 3 and nothing pops; then ready=1 → 3 then 4.
- Full/overflow: lane 3 pushes 5 times with ready=0, DEPTH=4 → lane_full[3]=1 after the 4th push; the 5th push sets overflow=1; the drain yields only the first 4 tags.
- Flush: lanes 0 and 2 hold entries, then flush=1 together with a lane 1 push → finish_valid=0 that cycle; next cycle all empty, finish_valid=0, lane 1 entry absent, overflow unchanged.
- Reset mid-operation: 3 entries buffered and overflow=1, then reset=1 for one edge → all outputs 0 after that edge; a subsequent lane 0 push of tag 7 emerges as the first grant.

Source files
------------

// File: rtl/completion_arbiter_pkg.sv
// Shared constants for the completion path: instruction field positions,
// lane identifiers, default sizes and the multi-cycle unit latencies.
package completion_arbiter_pkg;

    localparam int OPC_HI = 31, OPC_LO = 27;
    localparam int RD_HI  = 26, RD_LO  = 22;
    localparam int RS1_HI = 21, RS1_LO = 17;
    localparam int RS2_HI = 16, RS2_LO = 12;
    localparam int RD_W   = RD_HI - RD_LO + 1;

    typedef enum logic [1:0] {
        LANE_ALU = 2'd0,
        LANE_LW  = 2'd1,
        LANE_MUL = 2'd2,
        LANE_DIV = 2'd3
    } laneId_e;

    localparam int ROB_SIZE   = 32;
    localparam int SCORE_SIZE = 32;

    localparam int LAT_LW  = 8;
    localparam int LAT_MUL = 16;
    localparam int LAT_DIV = 32;

    // Rotation step for the round-robin pointer, valid for any lane count.
    function automatic int nextLane(input int idx, input int numUnits);
        return (idx + 1 >= numUnits) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/completion_arbiter_if.sv
// Lane-side and finish-side signals of the completion arbiter.
interface completion_arbiter_if
    import completion_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int ROB_SIZE  = 32
);
    localparam int TAG_W  = $clog2(ROB_SIZE);
    localparam int LANE_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]       lane_valid;
    logic [NUM_UNITS*TAG_W-1:0] lane_tag;
    logic [NUM_UNITS*RD_W-1:0]  lane_rd;
    logic [NUM_UNITS-1:0]       lane_full;
    logic                       finish_ready;
    logic                       finish_valid;
    logic [TAG_W-1:0]           finish_tag;
    logic [RD_W-1:0]            finish_rd;
    logic [LANE_W-1:0]          finish_lane;
    logic                       flush;
    logic                       overflow;

    modport slave (
        input  lane_valid, lane_tag, lane_rd, finish_ready, flush,
        output lane_full, finish_valid, finish_tag, finish_rd, finish_lane, overflow
    );

    modport master (
        output lane_valid, lane_tag, lane_rd, finish_ready, flush,
        input  lane_full, finish_valid, finish_tag, finish_rd, finish_lane, overflow
    );
endinterface

// File: rtl/completion_lane_fifo.sv
// Per-lane completion buffer. A push into a full FIFO is dropped even when the
// same cycle pops; clr empties the FIFO and wins over any push.
module completion_lane_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [PW:0]   count;
    logic          doPush, doPop;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/completion_arbiter.sv
// Buffers completions from each execution lane and hands one per cycle to the
// Scoreboard finish port, rotating priority after every accepted grant.
module completion_arbiter
    import completion_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int ROB_SIZE  = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    completion_arbiter_if.slave  bus
);
    localparam int TAG_W  = $clog2(ROB_SIZE);
    localparam int LANE_W = $clog2(NUM_UNITS);
    localparam int W      = TAG_W + RD_W;

    logic [NUM_UNITS-1:0][W-1:0] head;
    logic [NUM_UNITS-1:0]        emptyVec, fullVec, popVec;
    logic [LANE_W-1:0]           rrPtr, grant;
    logic                        found, finishValid, overflowQ;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : gLane
        completion_lane_fifo #(.W(W), .DEPTH(DEPTH)) uFifo (
            .clock (clock),
            .reset (reset),
            .clr   (bus.flush),
            .push  (bus.lane_valid[i]),
            .pop   (popVec[i]),
            .din   ({bus.lane_tag[i*TAG_W +: TAG_W], bus.lane_rd[i*RD_W +: RD_W]}),
            .dout  (head[i]),
            .empty (emptyVec[i]),
            .full  (fullVec[i])
        );
    end

    // First non-empty lane at or after rrPtr in rotation order.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!found && !emptyVec[idx]) begin
                found = 1'b1;
                grant = LANE_W'(idx);
            end
        end
    end

    assign finishValid = found && !bus.flush;

    always_comb begin
        popVec = '0;
        if (finishValid && bus.finish_ready) popVec[grant] = 1'b1;
    end

    assign bus.finish_valid = finishValid;
    assign bus.finish_tag   = finishValid ? head[grant][W-1:RD_W] : '0;
    assign bus.finish_rd    = finishValid ? head[grant][RD_W-1:0] : '0;
    assign bus.finish_lane  = finishValid ? grant : '0;
    assign bus.lane_full    = fullVec;
    assign bus.overflow     = overflowQ;

    always_ff @(posedge clock) begin
        if (reset || bus.flush)
            rrPtr <= '0;
        else if (finishValid && bus.finish_ready)
            rrPtr <= LANE_W'(nextLane(int'(grant), NUM_UNITS));
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clock) begin
        if (reset)
            overflowQ <= 1'b0;
        else if (|(bus.lane_valid & fullVec))
            overflowQ <= 1'b1;
    end
endmodule
